// File: rtl/sata_fis_pkg.sv
// Shared SATA FIS definitions: FIS type codes, payload limit
// and the transmit framer state type.
package sata_fis_pkg;

   localparam logic [7:0] FIS_REG_H2D = 8'h27;
   localparam logic [7:0] FIS_REG_D2H = 8'h34;
   localparam logic [7:0] FIS_DATA    = 8'h46;
   localparam logic [7:0] FIS_DMA_SET = 8'h41;

   localparam int SATA_MAX_PLD_DW = 2048;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_PLD  = 2'd2,
      ST_DROP = 2'd3
   } fis_state_t;

endpackage

// File: rtl/sata_fis_hdr_shifter.sv
// Loadable header shift register: dword 0 leaves first,
// with a remaining-length counter and a last-dword flag.
module sata_fis_hdr_shifter #(
   parameter int MAX_HDR_DW = 7,
   parameter int LW = $clog2(MAX_HDR_DW + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [MAX_HDR_DW*32-1:0] load_dat,
   input  logic [LW-1:0]           load_len,
   input  logic                    shift,
   output logic [31:0]             dat,
   output logic                    last
);

   logic [MAX_HDR_DW*32-1:0] sr;
   logic [LW-1:0]            rem;

   always_ff @(posedge clk) begin
      if (reset) begin
         sr  <= '0;
         rem <= '0;
      end else if (load) begin
         sr  <= load_dat;
         rem <= load_len;
      end else if (shift && rem != '0) begin
         sr  <= sr >> 32;
         rem <= rem - LW'(1);
      end
   end

   assign dat  = sr[31:0];
   assign last = (rem == LW'(1));

endmodule

// File: rtl/sata_fis_tx_framer.sv
// SATA transmit FIS framer: header dwords then optional payload.
// Optional counters: define SATA_FIS_TX_FRAMER_STAT_EN.
module sata_fis_tx_framer
   import sata_fis_pkg::*;
#(
   parameter int MAX_HDR_DW = 7,
   parameter int MAX_PLD_DW = SATA_MAX_PLD_DW,
   localparam int LW = $clog2(MAX_HDR_DW + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [MAX_HDR_DW*32-1:0] i_hdr_dat,
   input  logic [LW-1:0]            i_hdr_len,
   input  logic                     i_hdr_pld,
   input  logic                     i_hdr_val,
   output logic                     i_hdr_rdy,
   input  logic [31:0]              i_pld_dat,
   input  logic                     i_pld_val,
   input  logic                     i_pld_eop,
   output logic                     i_pld_rdy,
   output logic [31:0]              o_dat,
   output logic                     o_val,
   output logic                     o_eop,
   input  logic                     o_rdy,
`ifdef SATA_FIS_TX_FRAMER_STAT_EN
   output logic [31:0]              o_stat_fis,
   output logic [15:0]              o_stat_trunc,
`endif
   output logic                     o_err
);

   localparam int CW = (MAX_PLD_DW > 1) ? $clog2(MAX_PLD_DW) : 1;

   fis_state_t     state, state_nxt;
   logic           pld_flag;
   logic [CW-1:0]  pld_cnt;
   logic           err;
   logic [LW-1:0]  eff_len;
   logic           hdr_acc, out_xfer, pld_xfer, at_lim;
   logic [31:0]    sh_dat;
   logic           sh_last;

   always_comb begin
      eff_len = i_hdr_len;
      if (i_hdr_len == '0)
         eff_len = LW'(1);
      else if (i_hdr_len > LW'(MAX_HDR_DW))
         eff_len = LW'(MAX_HDR_DW);
   end

   assign hdr_acc  = i_hdr_val & i_hdr_rdy;
   assign out_xfer = o_val & o_rdy;
   assign pld_xfer = (state == ST_PLD) & out_xfer;
   assign at_lim   = (pld_cnt == CW'(MAX_PLD_DW - 1));

   sata_fis_hdr_shifter #(
      .MAX_HDR_DW (MAX_HDR_DW),
      .LW         (LW)
   ) u_shift (
      .clk      (clk),
      .reset    (reset),
      .load     (hdr_acc),
      .load_dat (i_hdr_dat),
      .load_len (eff_len),
      .shift    ((state == ST_HDR) & o_rdy),
      .dat      (sh_dat),
      .last     (sh_last)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Counter holds at the limit; the limit check ends the frame first.
   always_ff @(posedge clk) begin
      if (reset) begin
         pld_flag <= 1'b0;
         pld_cnt  <= '0;
         err      <= 1'b0;
      end else begin
         err <= pld_xfer & at_lim & ~i_pld_eop;
         if (hdr_acc) begin
            pld_flag <= i_hdr_pld;
            pld_cnt  <= '0;
         end else if (pld_xfer && !at_lim) begin
            pld_cnt  <= pld_cnt + CW'(1);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (i_hdr_val) state_nxt = ST_HDR;
         ST_HDR:
            if (o_rdy && sh_last)
               state_nxt = pld_flag ? ST_PLD : ST_IDLE;
         ST_PLD:
            if (pld_xfer) begin
               if (i_pld_eop)   state_nxt = ST_IDLE;
               else if (at_lim) state_nxt = ST_DROP;
            end
         ST_DROP:
            if (i_pld_val && i_pld_eop) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      i_hdr_rdy = 1'b0;
      i_pld_rdy = 1'b0;
      o_dat     = '0;
      o_val     = 1'b0;
      o_eop     = 1'b0;
      unique case (state)
         ST_IDLE: i_hdr_rdy = 1'b1;
         ST_HDR: begin
            o_val = 1'b1;
            o_dat = sh_dat;
            o_eop = sh_last & ~pld_flag;
         end
         ST_PLD: begin
            o_dat     = i_pld_dat;
            o_val     = i_pld_val;
            o_eop     = i_pld_eop | at_lim;
            i_pld_rdy = o_rdy;
         end
         ST_DROP: i_pld_rdy = 1'b1;
         default: ;
      endcase
   end

   assign o_err = err;

`ifdef SATA_FIS_TX_FRAMER_STAT_EN
   logic [31:0] stat_fis;
   logic [15:0] stat_trunc;

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_fis   <= '0;
         stat_trunc <= '0;
      end else begin
         if (out_xfer && o_eop && !(&stat_fis))
            stat_fis <= stat_fis + 32'd1;
         if (err && !(&stat_trunc))
            stat_trunc <= stat_trunc + 16'd1;
      end
   end

   assign o_stat_fis   = stat_fis;
   assign o_stat_trunc = stat_trunc;
`endif

endmodule

// File: doc/sata_fis_tx_framer.md
Name: sata_fis_tx_framer

Overview:
- Generic SATA transmit FIS framer: accepts a parallel header of 1..MAX_HDR_DW dwords and optionally appends a streamed payload.
- Serialises the result into one 32-bit stream with an end-of-packet marker.
- Successor to the fixed 5-dword Register FIS sender; covers Register H2D, Data, DMA Setup and similar FIS types through one block.
- Sits between the command layer and the link-layer transmit interface.

Parameters:
- MAX_HDR_DW, 7, maximum header length in dwords (>=1).
- MAX_PLD_DW, 2048, maximum payload dwords per FIS (SATA 8 KB limit); enforced by truncation.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_hdr_dat  in  MAX_HDR_DW*32  header dwords; dword 0 in bits [31:0], sent first
- i_hdr_len  in  $clog2(MAX_HDR_DW+1)  header length in dwords
- i_hdr_pld  in  1  payload follows the header
- i_hdr_val  in  1  header valid
- i_hdr_rdy  out  1  header accepted when i_hdr_val & i_hdr_rdy
- i_pld_dat  in  32  payload dword
- i_pld_val  in  1  payload valid
- i_pld_eop  in  1  last payload dword
- i_pld_rdy  out  1  payload ready
- o_dat  out  32  output dword
- o_val  out  1  output valid
- o_eop  out  1  last dword of FIS, qualified by o_val
- o_rdy  in  1  downstream ready
- o_err  out  1  one-cycle pulse: payload truncated at MAX_PLD_DW

Behaviour:
- Reset is synchronous and active-high. After reset:
  - state IDLE
  - i_hdr_rdy=1
  - o_val=0, o_eop=0, o_err=0, i_pld_rdy=0
  - header register and counters cleared
- States: IDLE, HDR, PLD, DROP.
- IDLE:
  - i_hdr_rdy=1, o_val=0.
  - On header accept, latch i_hdr_dat, i_hdr_pld and the effective length. Length 0 clamps to 1; length > MAX_HDR_DW clamps to MAX_HDR_DW.
  - Next state HDR.
  - Header-to-first-output latency: 1 cycle.
- HDR:
  - o_val=1; o_dat = current header dword from the shift register.
  - Each o_val & o_rdy shifts by one dword.
  - o_eop=1 on the last header dword only when i_hdr_pld=0.
  - After the last dword transfers: go to PLD if i_hdr_pld=1, otherwise go to IDLE.
  - i_hdr_rdy rises in the cycle after the final transfer, so back-to-back FISes have one idle cycle between them.
- PLD:
  - Combinational pass-through: o_dat=i_pld_dat, o_val=i_pld_val, i_pld_rdy=o_rdy.
  - Payload counter increments on each transfer.
  - o_eop = i_pld_eop | (pld_cnt == MAX_PLD_DW-1).
  - Transfer with i_pld_eop: go to IDLE.
  - Transfer at the limit without i_pld_eop: go to DROP and pulse o_err in the next cycle.
- DROP:
  - i_pld_rdy=1, o_val=0; payload is discarded.
  - Transfer with i_pld_val & i_pld_eop: go to IDLE.
- Boundary rules:
  - o_rdy held low: o_dat, o_val and o_eop stay stable; no shift.
  - i_pld_val while in IDLE or HDR is ignored (i_pld_rdy=0).
  - Header with i_hdr_pld=1 and a payload of only one eop dword is legal; the FIS is header plus 1 dword.
  - Counter width is $clog2(MAX_PLD_DW); the counter never wraps, because the limit check fires first.
  - Reset asserted mid-frame aborts immediately with no o_eop; the partial frame is the link layer's concern.

Optional Feature:
- Macro: SATA_FIS_TX_FRAMER_STAT_EN
- With the macro defined, the block adds two outputs:
  - o_stat_fis [31:0]: counts completed FISes, i.e. transfers with o_eop.
  - o_stat_trunc [15:0]: counts o_err pulses.
  - Both counters saturate, clear on reset, and update one cycle after the event.
- Without the macro: the ports and logic are absent and the behaviour is otherwise identical.

Decomposition:
- Package sata_fis_pkg holds:
  - FIS type constants: 8'h27 Register H2D, 8'h34 Register D2H, 8'h46 Data, 8'h41 DMA Setup.
  - SATA_MAX_PLD_DW = 2048.
  - The framer state enum type.
- Sub-module sata_fis_hdr_shifter: loadable MAX_HDR_DW x 32 shift register with a remaining-length counter and a last flag. The top level keeps the FSM, the pass-through and the truncation logic.

Test Plan:
- Register FIS: header len=5, pld=0, o_rdy=1 → 5 consecutive output dwords equal to hdr[0..4], o_eop on the 5th only, i_hdr_rdy back high 1 cycle later.
- Data FIS: header len=1 (0x00000046), pld=1, 4 payload dwords with eop on the 4th → 5 output dwords, o_eop on dword 5, o_err=0.
- Backpressure: o_rdy toggled 1/0 every cycle during a len=7 header → o_dat and o_eop stable while o_rdy=0, all 7 dwords delivered in order.
- Truncation with MAX_PLD_DW=4: 6 payload dwords, eop on the 6th → 4 payload dwords output with o_eop on the 4th, o_err pulse once, dwords 5 and 6 consumed in DROP, then IDLE.
- Clamping and reset: i_hdr_len=0 → 1 dword with eop; reset asserted in HDR on the 3rd dword → next cycle o_val=0, i_hdr_rdy=1; with STAT_EN, o_stat_fis unchanged by the aborted frame.
